mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits (range 1..15).

REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports listed as name, direction, width, meaning:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-low reset.

REQ-003 The block SHALL have these fetch-side ports:
- if_req, in, 1, fetch request.
- if_addr, in, ADDR_W, fetch address.
- if_flush, in, 1, discard in-flight fetch (branch/jump taken).
- if_rdata, out, DATA_W, fetched instruction.
- if_valid, out, 1, fetch completion pulse.
- stall_if, out, 1, fetch waiting.

REQ-004 The block SHALL have these data-side ports:
- d_req, in, 1, data request (MemRead or MemWrite).
- d_we, in, 1, 1 = store.
- d_addr, in, ADDR_W, data address.
- d_wdata, in, DATA_W, store data.
- d_rdata, out, DATA_W, load data.
- d_valid, out, 1, data completion pulse.
- stall_mem, out, 1, data waiting.

REQ-005 The block SHALL have these memory-side ports:
- mem_req, out, 1, access request.
- mem_we, out, 1, write enable.
- mem_addr, out, ADDR_W, address.
- mem_wdata, out, DATA_W, write data.
- mem_ready, in, 1, access complete.
- mem_rdata, in, DATA_W, read data.

Function
REQ-006 The block SHALL share one single-ported, variable-latency memory between the fetch requester and the data requester, with at most one transaction outstanding at a time.

REQ-007 The block SHALL implement an FSM with states IDLE, BUSY_I and BUSY_D.

REQ-008 In IDLE, the FSM SHALL transition at the clock edge as follows:
- d_req=1 and (if_req=0 or starve_cnt<STARVE_LIMIT): go to BUSY_D.
- Else if if_req=1: go to BUSY_I.
- Else: remain in IDLE.

REQ-009 On entering a BUSY state, the block SHALL register the granted requester's address, we and wdata into mem_addr/mem_we/mem_wdata; mem_we SHALL be 0 for fetch.

REQ-010 mem_req SHALL be 1 exactly while in BUSY_I or BUSY_D; the registered mem_addr, mem_we and mem_wdata SHALL be held stable until mem_ready=1.

REQ-011 mem_ready SHALL be ignored in IDLE.

REQ-012 In BUSY_D with mem_ready=1, the block SHALL:
- assert d_valid=1 for that cycle;
- drive d_rdata=mem_rdata combinationally, with d_rdata captured into a hold register;
- go to IDLE at the next edge.

REQ-013 In BUSY_I with mem_ready=1, the block SHALL drive if_valid=1 for that cycle unless the drop flag or if_flush is set, drive if_rdata=mem_rdata, and go to IDLE at the next edge.

REQ-014 Between completions, if_rdata and d_rdata SHALL hold the last captured values.

REQ-015 Minimum latency SHALL be: request in IDLE at cycle 0, mem_req at cycle 1, valid at cycle 1 when mem_ready=1 in cycle 1; back-to-back accesses cost one IDLE cycle each.

REQ-016 Requesters SHALL hold req/addr/wdata stable until their valid pulse and deassert req at the edge ending that pulse, or re-request in the following cycle.

REQ-017 stall_if SHALL equal if_req & ~if_valid.

REQ-018 stall_mem SHALL equal d_req & ~d_valid.

REQ-019 The 4-bit starvation counter starve_cnt SHALL:
- increment (saturating at STARVE_LIMIT) on each BUSY_D grant taken while if_req=1;
- clear on a BUSY_I grant or any IDLE cycle with if_req=0.

REQ-020 When starve_cnt=STARVE_LIMIT and both requests are active in IDLE, fetch SHALL win.

REQ-021 An if_flush pulse SHALL behave as follows:
- In BUSY_I, it sets the drop flag; the memory access completes normally but produces no if_valid, and the flag clears on leaving BUSY_I.
- In IDLE or BUSY_D, it has no effect.

REQ-022 If if_flush and mem_ready are both 1 in BUSY_I, if_valid SHALL be 0.

REQ-023 If d_req and if_req both rise in the same IDLE cycle with starve_cnt=0, data SHALL be granted and fetch SHALL stall.

Reset
REQ-024 Asserting rst low SHALL immediately force:
- state=IDLE, mem_req=0, mem_we=0;
- mem_addr=0, mem_wdata=0;
- if_valid=0, d_valid=0, if_rdata=0, d_rdata=0;
- starve_cnt=0, drop flag=0.

REQ-025 Reset asserted mid-transaction SHALL abandon the access, with no valid pulse after release.

REQ-026 After rst deasserts, the first grant SHALL occur at the first rising edge with a request present.

Verification
REQ-027 The bench SHALL cover at least these scenarios:
- Fetch only: if_addr=0x100, mem_ready 2 cycles after mem_req -> mem_addr=0x100, mem_we=0, single if_valid pulse with if_rdata=mem_rdata, stall_if high until then.
- Store: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, 0-wait memory -> mem_we=1 with that address/data for exactly one cycle, d_valid pulse, no if_valid.
- Contention: both requesting continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I, then counter cleared and D resumes.
- Flush: if_flush asserted in the second cycle of BUSY_I, mem_ready in the fourth -> no if_valid; next fetch at the new address returns normally.
- Reset mid-access: rst low during BUSY_D -> mem_req=0 and d_valid=0 asynchronously; after release with no request, mem_req stays 0.
- Simultaneous flush and ready in BUSY_I -> if_valid=0 and the FSM returns to IDLE next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported, variable-latency memory between fetch and data requesters
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_if,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state, state_nxt;
  logic [3:0]        starve_cnt, starve_nxt;
  logic              drop, drop_nxt;
  logic              grant_i, grant_d;
  logic              done;
  logic [DATA_W-1:0] if_hold, d_hold;

  // Arbitration only happens in IDLE; a BUSY state always returns to IDLE, so
  // back-to-back accesses pay one idle cycle each.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    drop_nxt   = drop;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        drop_nxt = 1'b0;
        if (d_req && (!if_req || starve_cnt < LIMIT)) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
          if (if_req)
            starve_nxt = (starve_cnt < LIMIT) ? starve_cnt + 4'd1 : LIMIT;
          else
            starve_nxt = 4'd0;
        end else if (if_req) begin
          grant_i    = 1'b1;
          state_nxt  = BUSY_I;
          starve_nxt = 4'd0;
        end else begin
          starve_nxt = 4'd0;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_nxt = IDLE;
          drop_nxt  = 1'b0;
        end else if (if_flush) begin
          drop_nxt = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done      = (state != IDLE) && mem_ready;
  assign mem_req   = (state != IDLE);
  assign d_valid   = (state == BUSY_D) && mem_ready;
  assign if_valid  = (state == BUSY_I) && mem_ready && !drop && !if_flush;
  assign d_rdata   = d_valid ? mem_rdata : d_hold;
  // A flushed fetch still shows the returned word, but only a delivered one is kept.
  assign if_rdata  = ((state == BUSY_I) && mem_ready) ? mem_rdata : if_hold;
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      drop       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_hold    <= '0;
      d_hold     <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      drop       <= drop_nxt;
      if (grant_d) begin
        mem_addr  <= d_addr;
        mem_we    <= d_we;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_addr  <= if_addr;
        mem_we    <= 1'b0;
        mem_wdata <= '0;
      end else if (done) begin
        mem_we <= 1'b0;
      end
      if (d_valid)
        d_hold <= mem_rdata;
      if (if_valid)
        if_hold <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_valid, stall_if;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_valid, stall_mem;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_rdata(if_rdata),
    .if_valid(if_valid), .stall_if(stall_if),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_valid(d_valid), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct packed {logic [31:0] addr; logic we; logic [31:0] wdata; logic is_i;} grant_t;
  typedef struct packed {logic is_i; logic ifv; logic dv; logic [31:0] data;} done_t;

  grant_t      exp_grant[$];
  done_t       exp_done[$];
  logic [31:0] glog[$];
  logic [31:0] phys   [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];
  int n_chk = 0, n_fail = 0;
  int nifv = 0, ndv = 0, nwe = 0;

  // reference model state
  bit     m_busy, m_is_i, m_drop, f_pend, d_pend, exp_mem_req, in_reset;
  grant_t m_cur;
  int     cnt, lat_left, busy_idx;
  int     f_rate, d_rate, flush_rate, force_lat, flush_at;
  logic [31:0] flush_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] rd_phys(input logic [31:0] a);
    return phys.exists(a) ? phys[a] : init_val(a);
  endfunction
  function automatic logic [31:0] rd_shadow(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  // One clock cycle: requesters, memory model, then the reference arbiter.
  task automatic step();
    done_t  d;
    grant_t g;
    @(posedge clk); #1;
    if (m_busy) busy_idx++;
    if (!f_pend && $urandom_range(0, 99) < f_rate) begin
      f_pend  = 1'b1;
      if_addr = 32'h100 + 32'($urandom_range(0, 63) << 2);
    end
    if (!d_pend && $urandom_range(0, 99) < d_rate) begin
      d_pend  = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = 32'h2000 + 32'($urandom_range(0, 15) << 2);
      d_wdata = $urandom;
    end
    if_req   = f_pend;
    d_req    = d_pend;
    if_flush = 1'b0;
    if (f_pend && m_busy && m_is_i && busy_idx == flush_at) begin
      if_flush = 1'b1;
      if_addr  = flush_addr;
      flush_at = -1;
    end else if (f_pend && $urandom_range(0, 99) < flush_rate) begin
      if_flush = 1'b1;
      if_addr  = 32'h100 + 32'($urandom_range(0, 63) << 2);
    end
    mem_ready = m_busy ? (lat_left == 0) : 1'($urandom_range(0, 1));
    mem_rdata = mem_ready ? rd_phys(mem_addr) : $urandom;
    if (mem_ready && mem_req && mem_we) phys[mem_addr] = mem_wdata;
    exp_mem_req = m_busy;
    if (m_busy) begin
      if (mem_ready) begin
        d.is_i = m_is_i;
        d.ifv  = m_is_i && !(m_drop || if_flush);
        d.dv   = !m_is_i;
        d.data = rd_shadow(m_cur.addr);
        if (!m_is_i && m_cur.we) shadow[m_cur.addr] = m_cur.wdata;
        exp_done.push_back(d);
        if (!m_is_i) d_pend = 1'b0;
        else if (d.ifv) f_pend = 1'b0;
        m_busy = 1'b0;
      end else begin
        lat_left--;
        if (m_is_i && if_flush) m_drop = 1'b1;
      end
    end else begin
      m_busy = 1'b1;
      if (d_req && (!if_req || cnt < LIM)) begin
        g   = '{d_addr, d_we, d_wdata, 1'b0};
        cnt = if_req ? ((cnt + 1 > LIM) ? LIM : cnt + 1) : 0;
      end else if (if_req) begin
        g   = '{if_addr, 1'b0, 32'h0, 1'b1};
        cnt = 0;
      end else begin
        g      = '0;
        cnt    = 0;
        m_busy = 1'b0;
      end
      if (m_busy) begin
        m_cur    = g;
        m_is_i   = g.is_i;
        m_drop   = 1'b0;
        busy_idx = 0;
        lat_left = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        exp_grant.push_back(g);
      end
    end
  endtask

  task automatic run_until_idle(input string name);
    for (int i = 0; i < 60 && (f_pend || d_pend || m_busy); i++) step();
    chk(name, {f_pend, d_pend, m_busy}, 3'b000);
    step();
  endtask

  // Monitor: pops expected grants/completions whenever the DUT presents them.
  initial begin : monitor
    bit          active, h_if_known;
    logic [31:0] h_if, h_d;
    grant_t      cg;
    done_t       d;
    logic        e_ifv, e_dv;
    active = 0; h_if_known = 1; h_if = 0; h_d = 0; cg = '0;
    forever begin
      @(negedge clk);
      if (!rst || in_reset) begin
        active = 0; h_if_known = 1; h_if = 0; h_d = 0;
      end else begin
        chk("mem_req", mem_req, exp_mem_req);
        if (mem_we) nwe++;
        if (if_valid) nifv++;
        if (d_valid) ndv++;
        e_ifv = 1'b0;
        e_dv  = 1'b0;
        if (mem_req && !active) begin
          if (exp_grant.size() == 0) chk("grant_unexpected", 1, 0);
          else cg = exp_grant.pop_front();
          glog.push_back(mem_addr);
          active = 1;
        end
        if (mem_req) begin
          chk("mem_addr", mem_addr, cg.addr);
          chk("mem_we", mem_we, cg.we);
          if (cg.we) chk("mem_wdata", mem_wdata, cg.wdata);
        end
        if (mem_req && mem_ready) begin
          if (exp_done.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            d = exp_done.pop_front();
            e_ifv = d.ifv;
            e_dv  = d.dv;
            chk("if_valid", if_valid, d.ifv);
            chk("d_valid", d_valid, d.dv);
            if (d.is_i) begin
              chk("if_rdata", if_rdata, d.data);
              chk("d_rdata_hold", d_rdata, h_d);
              h_if_known = d.ifv;
              h_if = d.data;
            end else begin
              chk("d_rdata", d_rdata, d.data);
              if (h_if_known) chk("if_rdata_hold", if_rdata, h_if);
              h_d = d.data;
            end
          end
          active = 0;
        end else begin
          chk("if_valid_idle", if_valid, 0);
          chk("d_valid_idle", d_valid, 0);
          chk("d_rdata_hold", d_rdata, h_d);
          if (h_if_known) chk("if_rdata_hold", if_rdata, h_if);
        end
        chk("stall_if", stall_if, if_req & ~e_ifv);
        chk("stall_mem", stall_mem, d_req & ~e_dv);
      end
    end
  end

  initial begin : stimulus
    int n0, d0, w0;
    bit pat [6];
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    in_reset = 1; m_busy = 0; f_pend = 0; d_pend = 0; exp_mem_req = 0; cnt = 0;
    m_is_i = 0; m_drop = 0; m_cur = '0; lat_left = 0; busy_idx = 0;
    f_rate = 0; d_rate = 0; flush_rate = 0; force_lat = -1; flush_at = -1; flush_addr = 0;
    if_req = 0; if_addr = 0; if_flush = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    rst = 1; #1 rst = 0; #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_valids", {if_valid, d_valid}, 2'b00);
    chk("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    @(posedge clk); #2 rst = 1; in_reset = 0;

    // fetch only, memory ready two cycles after mem_req
    n0 = nifv; d0 = ndv; force_lat = 2;
    f_pend = 1; if_addr = 32'h100;
    run_until_idle("s1_bound");
    chk("s1_ifv_count", nifv - n0, 1);
    chk("s1_dv_count", ndv - d0, 0);
    chk("s1_addr", glog[glog.size() - 1], 32'h100);

    // store with zero-wait memory
    n0 = nifv; d0 = ndv; w0 = nwe; force_lat = 0;
    d_pend = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    run_until_idle("s2_bound");
    chk("s2_we_cycles", nwe - w0, 1);
    chk("s2_dv_count", ndv - d0, 1);
    chk("s2_ifv_count", nifv - n0, 0);
    chk("s2_mem_content", phys[32'h2000], 32'hDEAD_BEEF);

    // contention: both requesters continuously active
    glog.delete(); f_rate = 100; d_rate = 100;
    for (int i = 0; i < 80 && glog.size() < 6; i++) step();
    f_rate = 0; d_rate = 0;
    run_until_idle("s3_bound");
    chk("s3_grant_count", (glog.size() >= 6), 1);
    if (glog.size() >= 6)
      for (int i = 0; i < 6; i++) chk($sformatf("s3_grant_%0d_is_data", i), glog[i][13], pat[i]);

    // flush in the second BUSY_I cycle, memory ready in the fourth
    n0 = nifv; force_lat = 3; flush_at = 2; flush_addr = 32'h300;
    f_pend = 1; if_addr = 32'h180;
    run_until_idle("s4_bound");
    chk("s4_ifv_count", nifv - n0, 1);
    chk("s4_first_addr", glog[glog.size() - 2], 32'h180);
    chk("s4_refetch_addr", glog[glog.size() - 1], 32'h300);

    // flush coincident with mem_ready
    n0 = nifv; force_lat = 1; flush_at = 2; flush_addr = 32'h340;
    f_pend = 1; if_addr = 32'h200;
    run_until_idle("s6_bound");
    chk("s6_ifv_count", nifv - n0, 1);
    chk("s6_refetch_addr", glog[glog.size() - 1], 32'h340);

    // reset in the middle of a data access
    force_lat = 5; d_pend = 1; d_we = 0; d_addr = 32'h2010;
    step(); step();
    in_reset = 1; mem_ready = 1;
    #1 rst = 0; #1;
    chk("s5_mem_req", mem_req, 0);
    chk("s5_d_valid", d_valid, 0);
    chk("s5_mem_addr", mem_addr, 0);
    chk("s5_d_rdata", d_rdata, 0);
    m_busy = 0; cnt = 0; f_pend = 0; d_pend = 0; if_req = 0; d_req = 0; mem_ready = 0;
    exp_mem_req = 0; exp_grant.delete(); exp_done.delete();
    @(posedge clk); #2 rst = 1; in_reset = 0;
    n0 = nifv; d0 = ndv;
    for (int i = 0; i < 5; i++) step();
    chk("s5_no_valid_after", (nifv - n0) + (ndv - d0), 0);

    // randomized traffic
    force_lat = -1; flush_at = -1; f_rate = 30; d_rate = 30; flush_rate = 5;
    for (int i = 0; i < 2000; i++) step();
    f_rate = 0; d_rate = 0; flush_rate = 0;
    run_until_idle("rand_drain");
    chk("grant_queue_empty", exp_grant.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
